// File: rtl/cnn_tile_sched_if.sv
// Issue-side bus of the CNN tile scheduler: the start handshake plus the
// index tuple handed to the datapath with its valid/ready handshake.
interface cnn_tile_sched_if #(
  parameter int N_p = 1,
  parameter int M_p = 1,
  parameter int K_p = 3,
  parameter int R_p = 4,
  parameter int C_p = 4
);
  localparam int WN = (N_p > 1) ? $clog2(N_p) : 1;
  localparam int WM = (M_p > 1) ? $clog2(M_p) : 1;
  localparam int WK = (K_p > 1) ? $clog2(K_p) : 1;
  localparam int WR = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int WC = (C_p > 1) ? $clog2(C_p) : 1;

  logic          valid_i;
  logic          ready_o;
  logic          issue_v_o;
  logic          issue_ready_i;
  logic [WM-1:0] to_o;
  logic [WN-1:0] ti_o;
  logic [WR-1:0] row_o;
  logic [WC-1:0] col_o;
  logic [WK-1:0] ki_o;
  logic [WK-1:0] kj_o;
  logic          first_o;
  logic          last_o;

  // Scheduler side: accepts start requests and drives the index tuple.
  modport master (
    input  valid_i, issue_ready_i,
    output ready_o, issue_v_o, to_o, ti_o, row_o, col_o, ki_o, kj_o, first_o, last_o
  );

  // Host/datapath side: requests runs and consumes tuples.
  modport slave (
    output valid_i, issue_ready_i,
    input  ready_o, issue_v_o, to_o, ti_o, row_o, col_o, ki_o, kj_o, first_o, last_o
  );
endinterface

// File: rtl/cnn_tile_sched.sv
// CNN tile loop-nest scheduler. Walks the nest to/ti/row/col/ki/kj (outermost
// to innermost), presenting one index tuple per accepted transfer, then waits
// for the datapath to drain before pulsing done.
module cnn_tile_sched #(
  parameter int N_p  = 1,
  parameter int M_p  = 1,
  parameter int K_p  = 3,
  parameter int R_p  = 4,
  parameter int C_p  = 4,
  parameter int Tn_p = 1,
  parameter int Tm_p = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  cnn_tile_sched_if.master bus,
  input  logic             dp_idle_i,
  output logic             done_o,
  output logic             busy_o
);
  localparam int WN = (N_p > 1) ? $clog2(N_p) : 1;
  localparam int WM = (M_p > 1) ? $clog2(M_p) : 1;
  localparam int WK = (K_p > 1) ? $clog2(K_p) : 1;
  localparam int WR = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int WC = (C_p > 1) ? $clog2(C_p) : 1;

  // Terminal values and strides of each loop counter.
  localparam logic [WK-1:0] K_MAX   = WK'(K_p - 1);
  localparam logic [WC-1:0] C_MAX   = WC'(C_p - 1);
  localparam logic [WR-1:0] R_MAX   = WR'(R_p - 1);
  localparam logic [WN-1:0] TI_MAX  = WN'(N_p - Tn_p);
  localparam logic [WN-1:0] TI_STEP = WN'(Tn_p);
  localparam logic [WM-1:0] TO_MAX  = WM'(M_p - Tm_p);
  localparam logic [WM-1:0] TO_STEP = WM'(Tm_p);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [WM-1:0] to_q, to_d;
  logic [WN-1:0] ti_q, ti_d;
  logic [WR-1:0] row_q, row_d;
  logic [WC-1:0] col_q, col_d;
  logic [WK-1:0] ki_q, ki_d;
  logic [WK-1:0] kj_q, kj_d;
  logic          issue_v_q, issue_v_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  // Carry chain: a counter advances only when every inner counter wraps.
  logic xfer_s;
  logic cy_ki_s, cy_col_s, cy_row_s, cy_ti_s, cy_to_s, fin_s;

  assign xfer_s   = issue_v_q & bus.issue_ready_i;
  assign cy_ki_s  = xfer_s   & (kj_q  == K_MAX);
  assign cy_col_s = cy_ki_s  & (ki_q  == K_MAX);
  assign cy_row_s = cy_col_s & (col_q == C_MAX);
  assign cy_ti_s  = cy_row_s & (row_q == R_MAX);
  assign cy_to_s  = cy_ti_s  & (ti_q  == TI_MAX);
  assign fin_s    = cy_to_s  & (to_q  == TO_MAX);

  // Next-state, next-counter and next-output computation.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    ti_d    = ti_q;
    row_d   = row_q;
    col_d   = col_q;
    ki_d    = ki_q;
    kj_d    = kj_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          state_d = RUN;
          to_d    = '0;
          ti_d    = '0;
          row_d   = '0;
          col_d   = '0;
          ki_d    = '0;
          kj_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The final transfer wraps every counter back to zero.
        kj_d    = xfer_s   ? ((kj_q  == K_MAX)  ? '0 : kj_q  + WK'(1)) : kj_q;
        ki_d    = cy_ki_s  ? ((ki_q  == K_MAX)  ? '0 : ki_q  + WK'(1)) : ki_q;
        col_d   = cy_col_s ? ((col_q == C_MAX)  ? '0 : col_q + WC'(1)) : col_q;
        row_d   = cy_row_s ? ((row_q == R_MAX)  ? '0 : row_q + WR'(1)) : row_q;
        ti_d    = cy_ti_s  ? ((ti_q  == TI_MAX) ? '0 : ti_q  + TI_STEP) : ti_q;
        to_d    = cy_to_s  ? ((to_q  == TO_MAX) ? '0 : to_q  + TO_STEP) : to_q;
        state_d = fin_s ? DRAIN : RUN;
      end
      DRAIN: begin
        if (dp_idle_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        to_d    = '0;
        ti_d    = '0;
        row_d   = '0;
        col_d   = '0;
        ki_d    = '0;
        kj_d    = '0;
      end
    endcase

    issue_v_d = (state_d == RUN);
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    // Flags are qualified by valid so they read 0 whenever no tuple is shown.
    first_d   = issue_v_d & (ti_d == '0) & (ki_d == '0) & (kj_d == '0);
    last_d    = issue_v_d & (ti_d == TI_MAX) & (ki_d == K_MAX) & (kj_d == K_MAX);
  end

  // FSM state, loop counters and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      to_q      <= '0;
      ti_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ki_q      <= '0;
      kj_q      <= '0;
      issue_v_q <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      ti_q      <= ti_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ki_q      <= ki_d;
      kj_q      <= kj_d;
      issue_v_q <= issue_v_d;
      first_q   <= first_d;
      last_q    <= last_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.issue_v_o = issue_v_q;
  assign bus.to_o      = to_q;
  assign bus.ti_o      = ti_q;
  assign bus.row_o     = row_q;
  assign bus.col_o     = col_q;
  assign bus.ki_o      = ki_q;
  assign bus.kj_o      = kj_q;
  assign bus.first_o   = first_q;
  assign bus.last_o    = last_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_cnn_tile_sched.sv
// Directed bench for cnn_tile_sched: default configuration plus two tiled
// configurations, with expected tuples derived arithmetically from the
// transfer index.
module tb_cnn_tile_sched;
  localparam int K = 3;
  localparam int R = 4;
  localparam int C = 4;
  localparam int TOTAL = 144;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dp_idle = 1'b1;
  logic dp_idle_bc = 1'b1;
  logic done, busy, done_b, busy_b, done_c, busy_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cnn_tile_sched_if #(.N_p(1), .M_p(1), .K_p(3), .R_p(4), .C_p(4)) bus ();
  cnn_tile_sched_if #(.N_p(2), .M_p(2), .K_p(3), .R_p(4), .C_p(4)) busb ();
  cnn_tile_sched_if #(.N_p(4), .M_p(4), .K_p(3), .R_p(4), .C_p(4)) busc ();

  cnn_tile_sched #(.N_p(1), .M_p(1), .K_p(3), .R_p(4), .C_p(4), .Tn_p(1), .Tm_p(1)) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus), .dp_idle_i(dp_idle), .done_o(done), .busy_o(busy));
  cnn_tile_sched #(.N_p(2), .M_p(2), .K_p(3), .R_p(4), .C_p(4), .Tn_p(1), .Tm_p(1)) dut_b (
    .clk_i(clk), .reset_i(reset), .bus(busb), .dp_idle_i(dp_idle_bc), .done_o(done_b), .busy_o(busy_b));
  cnn_tile_sched #(.N_p(4), .M_p(4), .K_p(3), .R_p(4), .C_p(4), .Tn_p(2), .Tm_p(2)) dut_c (
    .clk_i(clk), .reset_i(reset), .bus(busc), .dp_idle_i(dp_idle_bc), .done_o(done_c), .busy_o(busy_c));

  // Results of the last collect() run.
  int r_n, r_order_bad, r_first_bad, r_stall_bad, r_stalls, r_bubble, r_extra;
  int r_done_cnt, r_gap, r_busy_bad, r_span;
  bit r_start_v;
  logic [11:0] r_first_tup, r_last_tup;

  // Expected tuple for transfer number n of a run (kj innermost).
  function automatic void model(input int n, input int nn, input int mm, input int tn, input int tm,
                                output int e_to, output int e_ti, output int e_row, output int e_col,
                                output int e_ki, output int e_kj, output int e_f, output int e_l);
    int q;
    e_kj = n % K;  q = n / K;
    e_ki = q % K;  q = q / K;
    e_col = q % C; q = q / C;
    e_row = q % R; q = q / R;
    e_ti = (q % (nn / tn)) * tn; q = q / (nn / tn);
    e_to = q * tm;
    if (mm < 1) e_to = -1;
    e_f = (e_ti == 0 && e_ki == 0 && e_kj == 0) ? 1 : 0;
    e_l = (e_ti == nn - tn && e_ki == K - 1 && e_kj == K - 1) ? 1 : 0;
  endfunction

  function automatic logic [11:0] snap();
    return {bus.to_o, bus.ti_o, bus.row_o, bus.col_o, bus.ki_o, bus.kj_o, bus.first_o, bus.last_o};
  endfunction

  // Drives one run of the default DUT and gathers observations (no verdicts).
  task automatic collect(input bit do_start, input bit rand_rdy, input bit vpulse,
                         input bit stop_at_done, input int hold, input int reset_at);
    logic [11:0] prev_tup, cur;
    bit prev_v, prev_rdy, rdy, xfer_done;
    int lc, first_cyc, done_cyc;
    int e_to, e_ti, e_row, e_col, e_ki, e_kj, e_f, e_l;
    r_n = 0; r_order_bad = 0; r_first_bad = -1; r_stall_bad = 0; r_stalls = 0; r_bubble = 0;
    r_extra = 0; r_done_cnt = 0; r_gap = -1; r_busy_bad = 0; r_span = -1; r_start_v = 1'b0;
    r_first_tup = '1; r_last_tup = '1;
    prev_tup = '0; prev_v = 1'b0; prev_rdy = 1'b1; xfer_done = 1'b0;
    lc = 0; first_cyc = 0; done_cyc = 0;
    if (do_start) begin
      bus.valid_i = 1'b1;
      @(negedge clk);
      bus.valid_i = 1'b0;
      r_start_v = bus.issue_v_o;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (reset_at >= 0 && r_n == reset_at) begin
        reset = 1'b1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          if (done) r_done_cnt++;
          if (bus.issue_v_o) r_extra++;
        end
        break;
      end
      cur = snap();
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.issue_v_o) begin
        if (prev_v && !prev_rdy && cur != prev_tup) r_stall_bad++;
      end else if (r_n > 0 && r_n < TOTAL) begin
        r_bubble++;
      end
      if (bus.issue_v_o && !rdy) r_stalls++;
      bus.issue_ready_i = rdy;
      if (bus.issue_v_o && r_n >= TOTAL) begin
        r_extra++;
      end else if (bus.issue_v_o && rdy) begin
        model(r_n, 1, 1, 1, 1, e_to, e_ti, e_row, e_col, e_ki, e_kj, e_f, e_l);
        if (int'(bus.to_o) != e_to || int'(bus.ti_o) != e_ti || int'(bus.row_o) != e_row ||
            int'(bus.col_o) != e_col || int'(bus.ki_o) != e_ki || int'(bus.kj_o) != e_kj ||
            int'(bus.first_o) != e_f || int'(bus.last_o) != e_l) begin
          if (r_order_bad == 0) r_first_bad = r_n;
          r_order_bad++;
        end
        if (r_n == 0) begin r_first_tup = cur; first_cyc = cyc; end
        if (r_n == TOTAL - 1) begin r_last_tup = cur; lc = cyc; xfer_done = 1'b1; r_span = cyc - first_cyc; end
        r_n++;
      end
      if (xfer_done && cyc >= lc + 1 && cyc <= lc + hold + 1 && !busy) r_busy_bad++;
      dp_idle = !(xfer_done && cyc >= lc + 1 && cyc <= lc + hold);
      bus.valid_i = vpulse && ((bus.issue_v_o && (r_n % 37 == 5)) ||
                               (xfer_done && cyc >= lc + 1 && cyc <= lc + hold && (cyc % 3 == 0)));
      if (done) begin
        r_done_cnt++;
        done_cyc = cyc;
        if (xfer_done) r_gap = cyc - lc;
        if (stop_at_done) break;
      end
      if (r_done_cnt > 0 && cyc >= done_cyc + 3) break;
      prev_v = bus.issue_v_o; prev_rdy = rdy; prev_tup = cur;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    bus.issue_ready_i = 1'b1;
    dp_idle = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.valid_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.issue_v_o !== 1'b0) begin errors++; $display("FAIL reset_issue_v: got %b want 0", bus.issue_v_o); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bus.first_o !== 1'b0) begin errors++; $display("FAIL reset_first: got %b want 0", bus.first_o); end
    checks++; if (bus.last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.last_o); end
    reset = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.ready_o); end
    checks++; if (bus.issue_v_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 0", bus.issue_v_o); end
  endtask

  task automatic test_basic();
    collect(1'b1, 1'b0, 1'b0, 1'b0, 0, -1);
    checks++; if (r_start_v !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b want 1", r_start_v); end
    checks++; if (r_n !== TOTAL) begin errors++; $display("FAIL basic_count: got %0d want %0d", r_n, TOTAL); end
    checks++; if (r_order_bad !== 0) begin errors++; $display("FAIL basic_order: got %0d bad (first at %0d) want 0", r_order_bad, r_first_bad); end
    checks++; if (r_bubble !== 0) begin errors++; $display("FAIL basic_bubble: got %0d want 0", r_bubble); end
    checks++; if (r_span !== TOTAL - 1) begin errors++; $display("FAIL basic_span: got %0d want %0d", r_span, TOTAL - 1); end
    checks++; if (r_first_tup !== 12'h002) begin errors++; $display("FAIL basic_first_tuple: got %h want 002", r_first_tup); end
    checks++; if (r_last_tup !== 12'h3E9) begin errors++; $display("FAIL basic_last_tuple: got %h want 3e9", r_last_tup); end
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", r_done_cnt); end
    checks++; if (r_gap !== 2) begin errors++; $display("FAIL basic_done_gap: got %0d want 2", r_gap); end
    checks++; if (r_extra !== 0) begin errors++; $display("FAIL basic_extra: got %0d want 0", r_extra); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL basic_end_ready: got %b want 1", bus.ready_o); end
  endtask

  task automatic test_stall_random();
    collect(1'b1, 1'b1, 1'b0, 1'b0, 0, -1);
    checks++; if (r_n !== TOTAL) begin errors++; $display("FAIL stall_count: got %0d want %0d", r_n, TOTAL); end
    checks++; if (r_order_bad !== 0) begin errors++; $display("FAIL stall_order: got %0d bad (first at %0d) want 0", r_order_bad, r_first_bad); end
    checks++; if (r_stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable want 0 (stalls %0d)", r_stall_bad, r_stalls); end
    checks++; if (r_bubble !== 0) begin errors++; $display("FAIL stall_bubble: got %0d want 0", r_bubble); end
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL stall_done_count: got %0d want 1", r_done_cnt); end
    checks++; if (r_gap !== 2) begin errors++; $display("FAIL stall_done_gap: got %0d want 2", r_gap); end
  endtask

  task automatic test_drain_hold();
    collect(1'b1, 1'b0, 1'b1, 1'b0, 10, -1);
    checks++; if (r_n !== TOTAL) begin errors++; $display("FAIL drain_count: got %0d want %0d", r_n, TOTAL); end
    checks++; if (r_busy_bad !== 0) begin errors++; $display("FAIL drain_busy: got %0d idle cycles want 0", r_busy_bad); end
    checks++; if (r_gap !== 12) begin errors++; $display("FAIL drain_done_gap: got %0d want 12", r_gap); end
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL drain_done_count: got %0d want 1", r_done_cnt); end
    checks++; if (r_extra !== 0) begin errors++; $display("FAIL drain_ignored_valid: got %0d extra want 0", r_extra); end
  endtask

  task automatic test_reset_midrun();
    collect(1'b1, 1'b0, 1'b1, 1'b0, 0, 50);
    checks++; if (r_n !== 50) begin errors++; $display("FAIL midrun_count: got %0d want 50", r_n); end
    checks++; if (r_done_cnt !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d want 0", r_done_cnt); end
    checks++; if (r_extra !== 0) begin errors++; $display("FAIL midrun_idle_after: got %0d want 0", r_extra); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL midrun_ready: got %b want 1", bus.ready_o); end
    collect(1'b1, 1'b0, 1'b0, 1'b0, 0, -1);
    checks++; if (r_first_tup !== 12'h002) begin errors++; $display("FAIL restart_first_tuple: got %h want 002", r_first_tup); end
    checks++; if (r_n !== TOTAL) begin errors++; $display("FAIL restart_count: got %0d want %0d", r_n, TOTAL); end
    checks++; if (r_order_bad !== 0) begin errors++; $display("FAIL restart_order: got %0d bad want 0", r_order_bad); end
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL restart_done: got %0d want 1", r_done_cnt); end
  endtask

  task automatic test_back_to_back();
    collect(1'b1, 1'b0, 1'b0, 1'b1, 0, -1);
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL b2b_first_done: got %0d want 1", r_done_cnt); end
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    checks++; if (bus.issue_v_o !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", bus.issue_v_o); end
    checks++; if (snap() !== 12'h002) begin errors++; $display("FAIL b2b_tuple: got %h want 002", snap()); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width: got %b want 0", done); end
    collect(1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
    checks++; if (r_n !== TOTAL) begin errors++; $display("FAIL b2b_count: got %0d want %0d", r_n, TOTAL); end
    checks++; if (r_order_bad !== 0) begin errors++; $display("FAIL b2b_order: got %0d bad want 0", r_order_bad); end
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", r_done_cnt); end
  endtask

  task automatic test_tiled();
    int nb, nc, bad_b, bad_c, fb, lb, fc, lc, db, dc, ti_m, to_m;
    int e_to, e_ti, e_row, e_col, e_ki, e_kj, e_f, e_l;
    nb = 0; nc = 0; bad_b = 0; bad_c = 0; fb = 0; lb = 0; fc = 0; lc = 0; db = 0; dc = 0; ti_m = 0; to_m = 0;
    busb.issue_ready_i = 1'b1; busc.issue_ready_i = 1'b1;
    busb.valid_i = 1'b1; busc.valid_i = 1'b1;
    @(negedge clk);
    busb.valid_i = 1'b0; busc.valid_i = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (busb.issue_v_o) begin
        model(nb, 2, 2, 1, 1, e_to, e_ti, e_row, e_col, e_ki, e_kj, e_f, e_l);
        if (int'(busb.to_o) != e_to || int'(busb.ti_o) != e_ti || int'(busb.row_o) != e_row ||
            int'(busb.col_o) != e_col || int'(busb.ki_o) != e_ki || int'(busb.kj_o) != e_kj ||
            int'(busb.first_o) != e_f || int'(busb.last_o) != e_l) bad_b++;
        fb += int'(busb.first_o); lb += int'(busb.last_o); nb++;
      end
      if (busc.issue_v_o) begin
        model(nc, 4, 4, 2, 2, e_to, e_ti, e_row, e_col, e_ki, e_kj, e_f, e_l);
        if (int'(busc.to_o) != e_to || int'(busc.ti_o) != e_ti || int'(busc.row_o) != e_row ||
            int'(busc.col_o) != e_col || int'(busc.ki_o) != e_ki || int'(busc.kj_o) != e_kj ||
            int'(busc.first_o) != e_f || int'(busc.last_o) != e_l) bad_c++;
        ti_m |= (1 << int'(busc.ti_o)); to_m |= (1 << int'(busc.to_o));
        fc += int'(busc.first_o); lc += int'(busc.last_o); nc++;
      end
      if (done_b) db++;
      if (done_c) dc++;
      if (db > 0 && dc > 0) break;
      @(negedge clk);
    end
    checks++; if (nb !== 576) begin errors++; $display("FAIL tiled_b_count: got %0d want 576", nb); end
    checks++; if (bad_b !== 0) begin errors++; $display("FAIL tiled_b_order: got %0d bad want 0", bad_b); end
    checks++; if (fb !== 32) begin errors++; $display("FAIL tiled_b_first: got %0d want 32", fb); end
    checks++; if (lb !== 32) begin errors++; $display("FAIL tiled_b_last: got %0d want 32", lb); end
    checks++; if (db !== 1) begin errors++; $display("FAIL tiled_b_done: got %0d want 1", db); end
    checks++; if (nc !== 576) begin errors++; $display("FAIL tiled_c_count: got %0d want 576", nc); end
    checks++; if (bad_c !== 0) begin errors++; $display("FAIL tiled_c_order: got %0d bad want 0", bad_c); end
    checks++; if (ti_m !== 5) begin errors++; $display("FAIL tiled_c_ti_set: got %0d want 5", ti_m); end
    checks++; if (to_m !== 5) begin errors++; $display("FAIL tiled_c_to_set: got %0d want 5", to_m); end
    checks++; if (fc !== 32 || lc !== 32) begin errors++; $display("FAIL tiled_c_flags: got first %0d last %0d want 32 32", fc, lc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL tiled_c_done: got %0d want 1", dc); end
  endtask

  initial begin
    bus.valid_i = 1'b0;  bus.issue_ready_i = 1'b1;
    busb.valid_i = 1'b0; busb.issue_ready_i = 1'b1;
    busc.valid_i = 1'b0; busc.issue_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_stall_random();
    test_drain_hold();
    test_reset_midrun();
    test_back_to_back();
    test_tiled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
